// File: rtl/motor_controller_sysid_guard.sv
// Reads the system-ID slave (ID word, build timestamp) and enables the motor only when the words match.
// The ID slave is also shared with one host Avalon reader, which is serviced between checks.
module motor_controller_sysid_guard #(
   parameter logic [31:0] EXPECTED_ID    = 32'h20140830,
   parameter logic [31:0] EXPECTED_TS    = 32'h5400E662,
   parameter bit          CHECK_TS       = 1'b1,
   parameter int unsigned SETTLE_CYCLES  = 16,
   parameter int unsigned RECHECK_PERIOD = 0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        sys_address,
   input  logic [31:0] sys_readdata,
   input  logic        host_address,
   input  logic        host_read,
   output logic        host_waitrequest,
   output logic [31:0] host_readdata,
   output logic        busy,
   output logic        id_valid,
   output logic        id_match,
   output logic        ts_match,
   output logic        motor_enable,
   output logic [7:0]  fail_count
);

   typedef enum logic [2:0] {
      S_SETTLE,
      S_RD_ID,
      S_RD_TS,
      S_EVAL,
      S_IDLE,
      S_HOST1,
      S_HOST2
   } state_t;

   localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

   state_t      state_q, state_d;
   logic [15:0] settle_q, settle_d;
   logic [31:0] id_q, id_d;
   logic [31:0] ts_q, ts_d;
   logic        sys_addr_q, sys_addr_d;
   logic        wait_q, wait_d;
   logic [31:0] hrdata_q, hrdata_d;
   logic        busy_q, busy_d;
   logic        valid_q, valid_d;
   logic        idm_q, idm_d;
   logic        tsm_q, tsm_d;
   logic        men_q, men_d;
   logic [7:0]  fail_q, fail_d;
   logic        pend_q, pend_d;

   logic        id_ok, ts_ok, chk_pass;
   logic        tmr_exp;

   assign id_ok    = (id_q == EXPECTED_ID);
   assign ts_ok    = (ts_q == EXPECTED_TS);
   assign chk_pass = id_ok & (ts_ok | ~CHECK_TS);

   // Recheck timer exists only when a period is configured.
   generate
      if (RECHECK_PERIOD != 0) begin : g_tmr
         localparam logic [23:0] TMR_LOAD = 24'(RECHECK_PERIOD - 1);
         logic [23:0] tmr_q, tmr_d;
         logic        tmr_run;

         assign tmr_run = (state_q == S_IDLE) || (state_q == S_HOST1) || (state_q == S_HOST2);
         assign tmr_exp = (tmr_q == 24'd0);

         always_comb begin
            tmr_d = tmr_q;
            if (state_q == S_EVAL) begin
               tmr_d = TMR_LOAD;
            end else if (tmr_run && !tmr_exp) begin
               tmr_d = tmr_q - 24'd1;
            end
         end

         always_ff @(posedge clock) begin
            if (!reset_n) begin
               tmr_q <= 24'd0;
            end else begin
               tmr_q <= tmr_d;
            end
         end
      end else begin : g_no_tmr
         assign tmr_exp = 1'b0;
      end
   endgenerate

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      id_d     = id_q;
      ts_d     = ts_q;
      hrdata_d = hrdata_q;
      valid_d  = valid_q;
      idm_d    = idm_q;
      tsm_d    = tsm_q;
      men_d    = men_q;
      fail_d   = fail_q;
      pend_d   = pend_q;

      case (state_q)
         S_SETTLE: begin
            if (settle_q == 16'd0) begin
               state_d = S_RD_ID;
            end else begin
               settle_d = settle_q - 16'd1;
            end
         end
         S_RD_ID: begin
            id_d    = sys_readdata;
            state_d = S_RD_TS;
         end
         S_RD_TS: begin
            ts_d    = sys_readdata;
            state_d = S_EVAL;
         end
         S_EVAL: begin
            valid_d = 1'b1;
            idm_d   = id_ok;
            tsm_d   = ts_ok;
            men_d   = chk_pass;
            if (!chk_pass && fail_q != 8'hFF) begin
               fail_d = fail_q + 8'd1;
            end
            state_d = S_IDLE;
         end
         S_IDLE: begin
            // Host wins; a coincident start or timer expiry waits in pend_q.
            if (host_read) begin
               pend_d  = pend_q | start | tmr_exp;
               state_d = S_HOST1;
            end else if (start || pend_q || tmr_exp) begin
               pend_d  = 1'b0;
               state_d = S_RD_ID;
            end
         end
         S_HOST1: begin
            hrdata_d = sys_readdata;
            pend_d   = pend_q | start | tmr_exp;
            state_d  = S_HOST2;
         end
         S_HOST2: begin
            pend_d  = pend_q | start | tmr_exp;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_SETTLE;
         end
      endcase

      // Slave address and handshake outputs are registered from the next state.
      sys_addr_d = (state_d == S_RD_TS) || ((state_d == S_HOST1) && host_address);
      wait_d     = (state_d != S_HOST2);
      busy_d     = (state_d == S_SETTLE) || (state_d == S_RD_ID) ||
                   (state_d == S_RD_TS)  || (state_d == S_EVAL);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= S_SETTLE;
         settle_q   <= SETTLE_LOAD;
         id_q       <= 32'd0;
         ts_q       <= 32'd0;
         sys_addr_q <= 1'b0;
         wait_q     <= 1'b1;
         hrdata_q   <= 32'd0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         idm_q      <= 1'b0;
         tsm_q      <= 1'b0;
         men_q      <= 1'b0;
         fail_q     <= 8'd0;
         pend_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         settle_q   <= settle_d;
         id_q       <= id_d;
         ts_q       <= ts_d;
         sys_addr_q <= sys_addr_d;
         wait_q     <= wait_d;
         hrdata_q   <= hrdata_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
         idm_q      <= idm_d;
         tsm_q      <= tsm_d;
         men_q      <= men_d;
         fail_q     <= fail_d;
         pend_q     <= pend_d;
      end
   end

   assign sys_address      = sys_addr_q;
   assign host_waitrequest = wait_q;
   assign host_readdata    = hrdata_q;
   assign busy             = busy_q;
   assign id_valid         = valid_q;
   assign id_match         = idm_q;
   assign ts_match         = tsm_q;
   assign motor_enable     = men_q;
   assign fail_count       = fail_q;

endmodule

// File: tb/tb_motor_controller_sysid_guard.sv
// Bench for motor_controller_sysid_guard: directed table, hand sequences and a randomized model-checked phase.
module tb_motor_controller_sysid_guard;

   localparam logic [31:0] EXP_ID = 32'h20140830;
   localparam logic [31:0] EXP_TS = 32'h5400E662;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, start, start_nots, host_address, host_read;
   logic [31:0] slv_id, slv_ts;

   logic        sys_address, host_waitrequest, busy, id_valid, id_match, ts_match, motor_enable;
   logic [31:0] sys_readdata, host_readdata;
   logic [7:0]  fail_count;

   logic        n_sys_address, n_wr, n_busy, n_valid, n_idm, n_tsm, n_men;
   logic [31:0] n_readdata, n_hrdata;
   logic [7:0]  n_fail;

   logic        r_sys_address, r_wr, r_busy, r_valid, r_idm, r_tsm, r_men;
   logic [31:0] r_readdata, r_hrdata;
   logic [7:0]  r_fail;

   // Combinational ID slave model shared by all instances.
   assign sys_readdata = sys_address   ? slv_ts : slv_id;
   assign n_readdata   = n_sys_address ? slv_ts : slv_id;
   assign r_readdata   = r_sys_address ? slv_ts : slv_id;

   motor_controller_sysid_guard dut (
      .clock(clk), .reset_n(reset_n), .start(start),
      .sys_address(sys_address), .sys_readdata(sys_readdata),
      .host_address(host_address), .host_read(host_read),
      .host_waitrequest(host_waitrequest), .host_readdata(host_readdata),
      .busy(busy), .id_valid(id_valid), .id_match(id_match), .ts_match(ts_match),
      .motor_enable(motor_enable), .fail_count(fail_count)
   );

   motor_controller_sysid_guard #(.CHECK_TS(1'b0), .SETTLE_CYCLES(4)) u_nots (
      .clock(clk), .reset_n(reset_n), .start(start_nots),
      .sys_address(n_sys_address), .sys_readdata(n_readdata),
      .host_address(1'b0), .host_read(1'b0),
      .host_waitrequest(n_wr), .host_readdata(n_hrdata),
      .busy(n_busy), .id_valid(n_valid), .id_match(n_idm), .ts_match(n_tsm),
      .motor_enable(n_men), .fail_count(n_fail)
   );

   motor_controller_sysid_guard #(.RECHECK_PERIOD(100)) u_rc (
      .clock(clk), .reset_n(reset_n), .start(1'b0),
      .sys_address(r_sys_address), .sys_readdata(r_readdata),
      .host_address(1'b0), .host_read(1'b0),
      .host_waitrequest(r_wr), .host_readdata(r_hrdata),
      .busy(r_busy), .id_valid(r_valid), .id_match(r_idm), .ts_match(r_tsm),
      .motor_enable(r_men), .fail_count(r_fail)
   );

   int n_checks = 0;
   int n_err    = 0;

   // Behavioural model of the check results.
   int   m_fail;
   logic m_idm, m_tsm, m_me;

   typedef struct {
      bit          is_host;
      logic        addr;
      logic [31:0] id;
      logic [31:0] ts;
      logic        idm;
      logic        tsm;
      logic        me;
      int          fc;
      logic [31:0] rdata;
   } vec_t;

   vec_t tbl[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_sys_address"}, {31'd0, sys_address}, 32'd0);
      chk({tag, "_waitrequest"}, {31'd0, host_waitrequest}, 32'd1);
      chk({tag, "_readdata"}, host_readdata, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_id_valid"}, {31'd0, id_valid}, 32'd0);
      chk({tag, "_id_match"}, {31'd0, id_match}, 32'd0);
      chk({tag, "_ts_match"}, {31'd0, ts_match}, 32'd0);
      chk({tag, "_motor_enable"}, {31'd0, motor_enable}, 32'd0);
      chk({tag, "_fail_count"}, {24'd0, fail_count}, 32'd0);
   endtask

   // Wait for the first check after reset release; it must complete on cycle 19.
   task automatic post_reset(input string tag);
      int n;
      n = 0;
      while (id_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
         if (n == 1)  chk({tag, "_settle_busy"}, {31'd0, busy}, 32'd1);
         if (n == 17) chk({tag, "_rd_ts_addr"}, {31'd0, sys_address}, 32'd1);
         if (n == 18) chk({tag, "_eval_men"}, {31'd0, motor_enable}, 32'd0);
      end
      chk({tag, "_first_check_cycle"}, n, 32'd19);
      chk({tag, "_id_match"}, {31'd0, id_match}, 32'd1);
      chk({tag, "_ts_match"}, {31'd0, ts_match}, 32'd1);
      chk({tag, "_motor_enable"}, {31'd0, motor_enable}, 32'd1);
      chk({tag, "_fail_count"}, {24'd0, fail_count}, 32'd0);
      chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
      $display("%s: first check done after %0d cycles, motor_enable=%0b", tag, n, motor_enable);
   endtask

   task automatic do_check(input string tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_busy_rd_id"}, {31'd0, busy}, 32'd1);
      tick();
      chk({tag, "_addr_rd_ts"}, {31'd0, sys_address}, 32'd1);
      tick();
      chk({tag, "_busy_eval"}, {31'd0, busy}, 32'd1);
      tick();
      chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
      chk({tag, "_id_valid"}, {31'd0, id_valid}, 32'd1);
   endtask

   task automatic do_host(input string tag, input logic addr, input logic [31:0] exp);
      host_read    = 1'b1;
      host_address = addr;
      tick();
      chk({tag, "_wait_c1"}, {31'd0, host_waitrequest}, 32'd1);
      tick();
      chk({tag, "_wait_c2"}, {31'd0, host_waitrequest}, 32'd0);
      chk({tag, "_rdata"}, host_readdata, exp);
      host_read = 1'b0;
      tick();
      chk({tag, "_wait_back"}, {31'd0, host_waitrequest}, 32'd1);
      $display("%s: host read addr=%0d data=%h", tag, addr, host_readdata);
   endtask

   task automatic check_outputs(input string tag, input logic idm, input logic tsm, input logic me, input int fc);
      chk({tag, "_id_match"}, {31'd0, id_match}, {31'd0, idm});
      chk({tag, "_ts_match"}, {31'd0, ts_match}, {31'd0, tsm});
      chk({tag, "_motor_enable"}, {31'd0, motor_enable}, {31'd0, me});
      chk({tag, "_fail_count"}, {24'd0, fail_count}, fc);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n, p;
      logic fail;
      reset_n = 1'b0; start = 1'b0; start_nots = 1'b0;
      host_address = 1'b0; host_read = 1'b0;
      slv_id = EXP_ID; slv_ts = EXP_TS;

      tbl[0] = '{1'b0, 1'b0, 32'hDEADBEEF, EXP_TS, 1'b0, 1'b1, 1'b0, 1, 32'd0};
      tbl[1] = '{1'b0, 1'b0, EXP_ID, EXP_TS, 1'b1, 1'b1, 1'b1, 1, 32'd0};
      tbl[2] = '{1'b0, 1'b0, EXP_ID, 32'h11111111, 1'b1, 1'b0, 1'b0, 2, 32'd0};
      tbl[3] = '{1'b1, 1'b1, EXP_ID, EXP_TS, 1'b1, 1'b0, 1'b0, 2, EXP_TS};
      tbl[4] = '{1'b1, 1'b0, 32'h12345678, EXP_TS, 1'b1, 1'b0, 1'b0, 2, 32'h12345678};
      tbl[5] = '{1'b0, 1'b0, EXP_ID, EXP_TS, 1'b1, 1'b1, 1'b1, 2, 32'd0};

      repeat (3) tick();
      chk_reset("reset");
      reset_n = 1'b1;
      post_reset("boot");

      // Directed table.
      for (int i = 0; i < 6; i++) begin
         slv_id = tbl[i].id;
         slv_ts = tbl[i].ts;
         if (tbl[i].is_host) begin
            do_host($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].rdata);
         end else begin
            do_check($sformatf("tbl%0d", i));
            $display("tbl%0d: check id=%h ts=%h -> motor_enable=%0b fail_count=%0d",
                     i, tbl[i].id, tbl[i].ts, motor_enable, fail_count);
         end
         check_outputs($sformatf("tbl%0d", i), tbl[i].idm, tbl[i].tsm, tbl[i].me, tbl[i].fc);
      end
      slv_id = EXP_ID; slv_ts = EXP_TS;

      // Host read raised during RD_ID; a start in RD_ID must be ignored.
      start = 1'b1;
      tick();
      host_read = 1'b1; host_address = 1'b1;
      n = 0;
      while (host_waitrequest !== 1'b0 && n < 12) begin
         tick();
         start = 1'b0;
         n++;
      end
      chk("host_during_check_latency", n, 32'd5);
      chk("host_during_check_rdata", host_readdata, EXP_TS);
      host_read = 1'b0;
      tick();
      tick();
      chk("start_in_check_ignored", {31'd0, busy}, 32'd0);
      $display("host read during check: serviced after %0d cycles data=%h", n, host_readdata);

      // Host and start in the same IDLE cycle: host first, then the pending check.
      host_read = 1'b1; host_address = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("prio_host1_busy", {31'd0, busy}, 32'd0);
      chk("prio_host1_wait", {31'd0, host_waitrequest}, 32'd1);
      tick();
      chk("prio_host2_wait", {31'd0, host_waitrequest}, 32'd0);
      chk("prio_host2_rdata", host_readdata, EXP_ID);
      host_read = 1'b0;
      tick();
      chk("prio_idle_busy", {31'd0, busy}, 32'd0);
      tick();
      chk("prio_pending_check", {31'd0, busy}, 32'd1);
      repeat (3) tick();
      check_outputs("prio", 1'b1, 1'b1, 1'b1, 2);
      $display("host+start same cycle: pending check serviced, busy=%0b", busy);

      // Randomized phase against the behavioural model.
      m_fail = 2; m_idm = 1'b1; m_tsm = 1'b1; m_me = 1'b1;
      for (int i = 0; i < 40; i++) begin
         slv_id = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom();
         slv_ts = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom();
         if ($urandom_range(0, 2) == 0) begin
            p = $urandom_range(0, 1);
            do_host($sformatf("rnd%0d", i), p[0], p[0] ? slv_ts : slv_id);
         end else begin
            do_check($sformatf("rnd%0d", i));
            m_idm = (slv_id == EXP_ID);
            m_tsm = (slv_ts == EXP_TS);
            fail  = !(m_idm && m_tsm);
            m_me  = !fail;
            if (fail && m_fail < 255) m_fail++;
            $display("rnd%0d: check id=%h ts=%h -> motor_enable=%0b fail_count=%0d",
                     i, slv_id, slv_ts, motor_enable, fail_count);
         end
         check_outputs($sformatf("rnd%0d", i), m_idm, m_tsm, m_me, m_fail);
      end

      // Timestamp mismatch ignored when CHECK_TS=0.
      slv_id = EXP_ID; slv_ts = 32'hCAFEF00D;
      start_nots = 1'b1;
      tick();
      start_nots = 1'b0;
      repeat (3) tick();
      chk("nots_ts_match", {31'd0, n_tsm}, 32'd0);
      chk("nots_id_match", {31'd0, n_idm}, 32'd1);
      chk("nots_motor_enable", {31'd0, n_men}, 32'd1);
      $display("CHECK_TS=0 ts mismatch: ts_match=%0b motor_enable=%0b", n_tsm, n_men);

      // Saturation of fail_count.
      slv_id = 32'hDEADBEEF; slv_ts = EXP_TS;
      for (int i = 0; i < 300; i++) begin
         start = 1'b1;
         tick();
         start = 1'b0;
         repeat (3) tick();
      end
      chk("sat_fail_count", {24'd0, fail_count}, 32'd255);
      chk("sat_motor_enable", {31'd0, motor_enable}, 32'd0);
      $display("300 failing checks: fail_count=%0d", fail_count);

      // Reset asserted during RD_TS.
      slv_id = EXP_ID;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("abort_in_rd_ts", {31'd0, sys_address}, 32'd1);
      reset_n = 1'b0;
      tick();
      chk_reset("abort");
      reset_n = 1'b1;
      post_reset("rerun");

      // Recheck period measured between consecutive RD_TS cycles.
      n = 0;
      while (r_sys_address !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      chk("rc_first_found", {31'd0, r_sys_address}, 32'd1);
      tick();
      p = 1;
      while (r_sys_address !== 1'b1 && p < 300) begin
         tick();
         p++;
      end
      chk("rc_period", p, 32'd103);
      chk("rc_motor_enable", {31'd0, r_men}, 32'd1);
      $display("recheck period: %0d cycles", p);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
